// File: rtl/hazard_unit.sv
// hazard_unit: tracks producer destination registers through ID/EX, EX/MEM and MEM/WB,
// drives EX operand forwarding selects and the one-cycle load-use stall.
// Optional macro HAZARD_STATS_EN builds a saturating 16-bit stall-cycle counter.
module hazard_unit #(
  parameter int REG_W     = 5,
  parameter int NREG_ZERO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_wen,
  input  logic             id_load,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [15:0]      stall_cnt
);

  localparam logic [REG_W-1:0] REG_ZERO = REG_W'(NREG_ZERO);

  logic [REG_W-1:0] r_idex_rs;
  logic [REG_W-1:0] r_idex_rt;
  logic             r_idex_use_rs;
  logic             r_idex_use_rt;
  logic [REG_W-1:0] r_idex_dst;
  logic             r_idex_wen;
  logic             r_idex_load;
  logic             r_idex_valid;

  logic [REG_W-1:0] r_exmem_dst;
  logic             r_exmem_wen;
  logic             r_exmem_load;
  logic             r_exmem_valid;

  logic [REG_W-1:0] r_memwb_dst;
  logic             r_memwb_wen;
  logic             r_memwb_valid;

  logic w_stall;
  logic w_bubble;
  logic w_exmem_a;
  logic w_exmem_b;
  logic w_memwb_a;
  logic w_memwb_b;

  // A load reaching EX/MEM with a dependent consumer in EX is prevented by the stall,
  // so its load bit is carried along but never consulted.
  logic w_unused_exmem_load;
  assign w_unused_exmem_load = r_exmem_load;

  assign w_stall = r_idex_valid && r_idex_wen && r_idex_load
                && (r_idex_dst != REG_ZERO)
                && ((id_use_rs && (id_rs == r_idex_dst)) ||
                    (id_use_rt && (id_rt == r_idex_dst)))
                && !flush;
  assign stall    = w_stall;
  assign w_bubble = w_stall || flush;

  assign w_exmem_a = r_exmem_valid && r_exmem_wen && (r_exmem_dst == r_idex_rs)
                  && (r_idex_rs != REG_ZERO) && r_idex_use_rs;
  assign w_exmem_b = r_exmem_valid && r_exmem_wen && (r_exmem_dst == r_idex_rt)
                  && (r_idex_rt != REG_ZERO) && r_idex_use_rt;
  assign w_memwb_a = r_memwb_valid && r_memwb_wen && (r_memwb_dst == r_idex_rs)
                  && (r_idex_rs != REG_ZERO) && r_idex_use_rs;
  assign w_memwb_b = r_memwb_valid && r_memwb_wen && (r_memwb_dst == r_idex_rt)
                  && (r_idex_rt != REG_ZERO) && r_idex_use_rt;

  assign fwd_a = w_exmem_a ? 2'b01 : (w_memwb_a ? 2'b10 : 2'b00);
  assign fwd_b = w_exmem_b ? 2'b01 : (w_memwb_b ? 2'b10 : 2'b00);

  // Bubbles also drop their use bits so an empty EX slot never shows a forward select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex_rs     <= '0;
      r_idex_rt     <= '0;
      r_idex_use_rs <= 1'b0;
      r_idex_use_rt <= 1'b0;
      r_idex_dst    <= '0;
      r_idex_wen    <= 1'b0;
      r_idex_load   <= 1'b0;
      r_idex_valid  <= 1'b0;
    end else begin
      r_idex_rs  <= id_rs;
      r_idex_rt  <= id_rt;
      r_idex_dst <= id_dst;
      if (w_bubble) begin
        r_idex_use_rs <= 1'b0;
        r_idex_use_rt <= 1'b0;
        r_idex_wen    <= 1'b0;
        r_idex_load   <= 1'b0;
        r_idex_valid  <= 1'b0;
      end else begin
        r_idex_use_rs <= id_use_rs;
        r_idex_use_rt <= id_use_rt;
        r_idex_wen    <= id_wen;
        r_idex_load   <= id_load;
        r_idex_valid  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exmem_dst   <= '0;
      r_exmem_wen   <= 1'b0;
      r_exmem_load  <= 1'b0;
      r_exmem_valid <= 1'b0;
      r_memwb_dst   <= '0;
      r_memwb_wen   <= 1'b0;
      r_memwb_valid <= 1'b0;
    end else begin
      r_exmem_dst   <= r_idex_dst;
      r_exmem_wen   <= r_idex_wen;
      r_exmem_load  <= r_idex_load;
      r_exmem_valid <= r_idex_valid;
      r_memwb_dst   <= r_exmem_dst;
      r_memwb_wen   <= r_exmem_wen;
      r_memwb_valid <= r_exmem_valid;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the driver queues per-cycle expectations,
// a negedge monitor pops and compares stall, fwd_a, fwd_b and stall_cnt.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_use_rs = 1'b0;
  logic        id_use_rt = 1'b0;
  logic [4:0]  id_dst = '0;
  logic        id_wen = 1'b0;
  logic        id_load = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_cnt;

  typedef struct {
    string       nm;
    logic        st;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = '0;

  hazard_unit #(.REG_W(5), .NREG_ZERO(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_dst    (id_dst),
    .id_wen    (id_wen),
    .id_load   (id_load),
    .flush     (flush),
    .stall     (stall),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.nm, ".stall"}, {15'd0, stall}, {15'd0, e.st});
        check({e.nm, ".fwd_a"}, {14'd0, fwd_a}, {14'd0, e.fa});
        check({e.nm, ".fwd_b"}, {14'd0, fwd_b}, {14'd0, e.fb});
        check({e.nm, ".stall_cnt"}, stall_cnt, e.cnt);
      end
    end
  end

  // One ID-stage cycle: drive inputs just after the edge and queue the expected outputs.
  task automatic cyc(input string nm, input logic rv, input logic fl,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt,
                     input logic [4:0] dst, input logic wen, input logic ld,
                     input logic est, input logic [1:0] efa, input logic [1:0] efb);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rv; flush = fl;
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_wen = wen; id_load = ld;
    if (!rv) exp_cnt = '0;
    e.nm = nm; e.st = est; e.fa = efa; e.fb = efb; e.cnt = exp_cnt;
    q.push_back(e);
`ifdef HAZARD_STATS_EN
    if (est && rv && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
`endif
  endtask

  task automatic nop(input string nm, input logic [1:0] efa, input logic [1:0] efb);
    cyc(nm, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, efa, efb);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    cyc("reset",      1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc("reset_hold", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    // ALU chain: back-to-back, one gap, and EX/MEM over MEM/WB priority
    cyc("alu_add_r3",  1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc("alu_sub_id",  1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    nop("alu_fwd_exmem", 2'b01, 2'b00);
    cyc("gap_add_r3",  1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc("gap_or_r8",   1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc("gap_and_id",  1'b1, 1'b0, 5'd3, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    nop("gap_fwd_memwb", 2'b10, 2'b00);
    cyc("prio_add1",   1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc("prio_add2",   1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc("prio_sub_id", 1'b1, 1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    nop("prio_fwd_both", 2'b01, 2'b01);
    nop("drain_a", 2'b00, 2'b00);
    nop("drain_b", 2'b00, 2'b00);
    // Load-use on rt: one stall, bubble, then MEM/WB forward
    cyc("lu_lw_r5",   1'b1, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    cyc("lu_stall",   1'b1, 1'b0, 5'd6, 5'd5, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    cyc("lu_release", 1'b1, 1'b0, 5'd6, 5'd5, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    nop("lu_fwd_b", 2'b00, 2'b10);
    nop("drain_c", 2'b00, 2'b00);
    nop("drain_d", 2'b00, 2'b00);
    // Register zero never stalls or forwards
    cyc("r0_lw",  1'b1, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    cyc("r0_use", 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    nop("r0_nofwd_ex", 2'b00, 2'b00);
    nop("r0_nofwd_wb", 2'b00, 2'b00);
    // Flush overrides load-use and leaves a bubble
    cyc("fl_lw_r5", 1'b1, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    cyc("fl_kill",  1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    nop("fl_bubble_ex", 2'b00, 2'b00);
    nop("fl_bubble_wb", 2'b00, 2'b00);
    // Operand not read: no stall, no forward
    cyc("un_lw_r7",     1'b1, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    cyc("un_rt_unused", 1'b1, 1'b0, 5'd2, 5'd7, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    nop("un_nofwd", 2'b00, 2'b00);
    // Load-use on rs
    cyc("lurs_lw_r9",   1'b1, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    cyc("lurs_stall",   1'b1, 1'b0, 5'd9, 5'd2, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    cyc("lurs_release", 1'b1, 1'b0, 5'd9, 5'd2, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    nop("lurs_fwd_a", 2'b10, 2'b00);
    // Reset mid-stream while a load-use would otherwise stall
    cyc("rst_add_r3",  1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc("rst_lw_r4",   1'b1, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    cyc("rst_mid",     1'b0, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc("rst_hold",    1'b0, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc("rst_release", 1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    nop("rst_no_fwd", 2'b00, 2'b00);

    @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", 16'(q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
